// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and oversampling constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 7;

endpackage

// File: rtl/rx_sync_2ff.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle (high) level.
module rx_sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 16x-oversampled start/data/stop framing, LSB first, no parity.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);

    localparam logic [4:0] MID_CNT       = 5'(MID_SAMPLE);
    localparam logic [4:0] LAST_DATA_CNT = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] LAST_STOP_CNT = 5'(SB_TICK - 1);
    localparam logic [2:0] LAST_BIT      = 3'(DBIT - 1);

    state_t          state;
    logic [4:0]      s_cnt;
    logic [2:0]      n;
    logic [DBIT-1:0] b_reg;
    logic            stop_bit;
    logic            rx_s;

    rx_sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            s_cnt        <= '0;
            n            <= '0;
            b_reg        <= '0;
            stop_bit     <= 1'b0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                // A tick coinciding with the start edge is deliberately not counted.
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s_cnt <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_cnt == MID_CNT) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s_cnt <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            s_cnt <= s_cnt + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_cnt == LAST_DATA_CNT) begin
                            s_cnt <= '0;
                            b_reg <= {rx_s, b_reg[DBIT-1:1]};
                            if (n == LAST_BIT) begin
                                state <= STOP;
                            end else begin
                                n <= n + 3'd1;
                            end
                        end else begin
                            s_cnt <= s_cnt + 5'd1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s_cnt == LAST_STOP_CNT) begin
                            state        <= IDLE;
                            busy         <= 1'b0;
                            dout         <= b_reg;
                            frame_err    <= ~stop_bit;
                            rx_done_tick <= 1'b1;
                        end else begin
                            if (s_cnt == MID_CNT) begin
                                stop_bit <= rx_s;
                            end
                            s_cnt <= s_cnt + 5'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench: frames are sent on rx, expected bytes queued, a monitor checks each rx_done_tick.
`timescale 1ns / 1ps
module tb_uart_rx_ctrl;

    localparam int BIT_CLK = 208;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] dout_a;
    logic [6:0] dout_b;
    logic       done_a, done_b, fe_a, fe_b, busy_a, busy_b;

    int   vectors = 0;
    int   errors = 0;
    int   pulses_a = 0;
    int   pulses_b = 0;
    int   busy_cycles_a = 0;
    logic done_a_prev = 1'b0;
    logic done_b_prev = 1'b0;
    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t mon_e;

    uart_rx_ctrl #(.DBIT(8), .SB_TICK(16)) dut_a (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx           (rx_a),
        .dout         (dout_a),
        .rx_done_tick (done_a),
        .frame_err    (fe_a),
        .busy         (busy_a)
    );

    uart_rx_ctrl #(.DBIT(7), .SB_TICK(32)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx           (rx_b),
        .dout         (dout_b),
        .rx_done_tick (done_b),
        .frame_err    (fe_b),
        .busy         (busy_b)
    );

    always #250 clk = ~clk;

    // Baud generator stand-in: one-clk strobe every 13 clk.
    initial begin
        forever begin
            repeat (12) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (busy_a) busy_cycles_a++;
        if (done_a) begin
            pulses_a++;
            check("a_tick_align", 32'(s_tick), 32'd1);
            check("a_pulse_width", 32'(done_a_prev), 32'd0);
            if (exp_a.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL a_unexpected_pulse: got dout %0h, expected no pulse", dout_a);
            end else begin
                mon_e = exp_a.pop_front();
                check("a_dout", 32'(dout_a), 32'(mon_e.d));
                check("a_frame_err", 32'(fe_a), 32'(mon_e.fe));
            end
        end
        if (done_b) begin
            pulses_b++;
            check("b_tick_align", 32'(s_tick), 32'd1);
            check("b_pulse_width", 32'(done_b_prev), 32'd0);
            if (exp_b.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL b_unexpected_pulse: got dout %0h, expected no pulse", dout_b);
            end else begin
                mon_e = exp_b.pop_front();
                check("b_dout", 32'(dout_b), 32'(mon_e.d));
                check("b_frame_err", 32'(fe_b), 32'(mon_e.fe));
            end
        end
        done_a_prev = done_a;
        done_b_prev = done_b;
    end

    task automatic set_rx(input int which, input logic lv);
        if (which == 0) rx_a = lv;
        else rx_b = lv;
    endtask

    // Drives start, nbits data (LSB first), stop. cut >= 0 aborts halfway through bit slot cut.
    task automatic send(input int which, input logic [7:0] data, input int nbits,
                        input logic stop_lv, input int stop_clk, input bit align, input int cut);
        logic lv;
        int   len;
        if (align) begin
            // Start edge lands so the FSM enters START on a tick edge.
            @(posedge clk iff s_tick);
            repeat (11) @(negedge clk);
        end
        for (int i = 0; i <= nbits + 1; i++) begin
            len = BIT_CLK;
            if (i == 0) lv = 1'b0;
            else if (i <= nbits) lv = data[i-1];
            else begin
                lv  = stop_lv;
                len = stop_clk;
            end
            set_rx(which, lv);
            if (i == cut) begin
                repeat (BIT_CLK / 2) @(negedge clk);
                return;
            end
            repeat (len) @(negedge clk);
        end
        set_rx(which, 1'b1);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int p0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_dout_a", 32'(dout_a), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_fe_a", 32'(fe_a), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(20);

        // Single ideal 8N1 frame.
        exp_a.push_back('{d: 8'hA5, fe: 1'b0});
        p0 = pulses_a;
        busy_cycles_a = 0;
        send(0, 8'hA5, 8, 1'b1, BIT_CLK, 1'b1, -1);
        idle(300);
        check("t1_pulses", 32'(pulses_a - p0), 32'd1);
        check("t1_busy_len_ok", 32'(busy_cycles_a >= 9 * BIT_CLK && busy_cycles_a <= 10 * BIT_CLK),
              32'd1);
        check("t1_busy_low", 32'(busy_a), 32'd0);

        // Short glitch: rejected at the start-bit midpoint.
        p0 = pulses_a;
        busy_cycles_a = 0;
        rx_a = 1'b0;
        idle(39);
        rx_a = 1'b1;
        idle(200);
        check("t2_busy_pulsed", 32'(busy_cycles_a > 0), 32'd1);
        check("t2_busy_low", 32'(busy_a), 32'd0);
        check("t2_dout_held", 32'(dout_a), 32'hA5);
        check("t2_no_pulse", 32'(pulses_a - p0), 32'd0);

        // Stop bit low, then a normal frame.
        exp_a.push_back('{d: 8'h3C, fe: 1'b1});
        send(0, 8'h3C, 8, 1'b0, BIT_CLK, 1'b1, -1);
        idle(400);
        exp_a.push_back('{d: 8'h0F, fe: 1'b0});
        send(0, 8'h0F, 8, 1'b1, BIT_CLK, 1'b1, -1);
        idle(300);

        // Back-to-back frames with no idle gap.
        p0 = pulses_a;
        exp_a.push_back('{d: 8'h00, fe: 1'b0});
        exp_a.push_back('{d: 8'hFF, fe: 1'b0});
        send(0, 8'h00, 8, 1'b1, BIT_CLK, 1'b1, -1);
        send(0, 8'hFF, 8, 1'b1, BIT_CLK, 1'b0, -1);
        idle(300);
        check("t4_pulses", 32'(pulses_a - p0), 32'd2);

        // Reset during data bit 4; nothing partial may come out.
        p0 = pulses_a;
        send(0, 8'h81, 8, 1'b1, BIT_CLK, 1'b1, 5);
        check("t5_busy_before_rst", 32'(busy_a), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_busy", 32'(busy_a), 32'd0);
        check("t5_rst_dout", 32'(dout_a), 32'd0);
        check("t5_rst_fe", 32'(fe_a), 32'd0);
        idle(3);
        rx_a = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(300);
        check("t5_no_pulse", 32'(pulses_a - p0), 32'd0);
        exp_a.push_back('{d: 8'h5A, fe: 1'b0});
        send(0, 8'h5A, 8, 1'b1, BIT_CLK, 1'b1, -1);
        idle(300);

        // 7 data bits, 2 stop bits.
        p0 = pulses_b;
        exp_b.push_back('{d: 8'h55, fe: 1'b0});
        send(1, 8'h55, 7, 1'b1, 2 * BIT_CLK, 1'b1, -1);
        idle(300);
        check("t6_pulses", 32'(pulses_b - p0), 32'd1);
        check("t6_busy_low", 32'(busy_b), 32'd0);

        check("a_queue_drained", 32'(exp_a.size()), 32'd0);
        check("b_queue_drained", 32'(exp_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
